sample_readout: RTL and testbench

SAMPLE_READOUT -- requirements
Module: sample_readout

---
 rtl/la_pkg.sv | 18 +
 rtl/sample_readout_if.sv | 25 ++
 rtl/readout_addr_ctr.sv | 36 +++
 rtl/sample_readout.sv | 123 ++++++++++++
 tb/tb_sample_readout.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser readout path: default widths
// and the readout FSM state encoding.
package la_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } readout_state_e;

endpackage

// File: rtl/sample_readout_if.sv
// Capture-RAM read port plus the outgoing valid/ready sample stream.
// The master side is the readout engine; the slave side is RAM plus stream sink.
interface sample_readout_if #(
  parameter int ADDR_BITS = la_pkg::ADDR_BITS_DEF,
  parameter int DATA_BITS = la_pkg::DATA_BITS_DEF
);

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd_en;
  logic [DATA_BITS-1:0] mem_rd_data;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output mem_addr, mem_rd_en, m_data, m_valid,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, m_data, m_valid,
    output mem_rd_data, m_ready
  );

endinterface

// File: rtl/readout_addr_ctr.sv
// Wrapping capture-RAM address counter paired with the count of samples
// still to be emitted; 'last' flags the final sample of the readout.
module readout_addr_ctr #(
  parameter int ADDR_BITS = la_pkg::ADDR_BITS_DEF,
  parameter int CNT_BITS  = la_pkg::CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 inc,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [CNT_BITS-1:0]  load_cnt,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last
);

  logic [CNT_BITS-1:0] remaining;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_cnt;
    end else if (inc) begin
      addr      <= addr + ADDR_BITS'(1);
      remaining <= remaining - CNT_BITS'(1);
    end
  end

  assign last = (remaining == CNT_BITS'(1));

endmodule

// File: rtl/sample_readout.sv
// Reads a pre/post-trigger window out of the capture RAM onto a valid/ready
// stream. Optional trailing XOR checksum word: define SAMPLE_READOUT_CHECKSUM_EN.
module sample_readout
  import la_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] trig_addr,
  input  logic [CNT_BITS-1:0]  read_cnt,
  input  logic [CNT_BITS-1:0]  delay_cnt,
  output logic                 busy,
  output logic                 done,
  sample_readout_if.master     bus
);

  readout_state_e       state, next_state;
  logic [CNT_BITS-1:0]  pre_cnt;
  logic [ADDR_BITS-1:0] start_addr;
  logic [ADDR_BITS-1:0] addr;
  logic                 last;
  logic                 sample_hs;
  logic [DATA_BITS-1:0] m_data_q;

  // Samples before the trigger; none when the post-trigger count covers it all.
  assign pre_cnt    = (read_cnt > delay_cnt) ? read_cnt - delay_cnt : '0;
  assign start_addr = trig_addr - ADDR_BITS'(pre_cnt);

`ifdef SAMPLE_READOUT_CHECKSUM_EN
  logic                 csum_phase;
  logic [DATA_BITS-1:0] csum_q;

  assign sample_hs = (state == ST_SEND) && bus.m_ready && !abort && !csum_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q     <= '0;
      csum_phase <= 1'b0;
    end else begin
      if (state == ST_LOAD)
        csum_q <= '0;
      else if (sample_hs)
        csum_q <= csum_q ^ m_data_q;
      if (state != ST_SEND)
        csum_phase <= 1'b0;
      else if (sample_hs && last)
        csum_phase <= 1'b1;
    end
  end
`else
  assign sample_hs = (state == ST_SEND) && bus.m_ready && !abort;
`endif

  readout_addr_ctr #(
    .ADDR_BITS (ADDR_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_addr_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_LOAD),
    .inc       (sample_hs),
    .load_addr (start_addr),
    .load_cnt  (read_cnt),
    .addr      (addr),
    .last      (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_LOAD;
      ST_LOAD:  next_state = (read_cnt == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: next_state = ST_WAIT;
      ST_WAIT:  next_state = ST_SEND;
      ST_SEND: begin
        if (bus.m_ready) begin
`ifdef SAMPLE_READOUT_CHECKSUM_EN
          if (csum_phase)  next_state = ST_DONE;
          else if (last)   next_state = ST_SEND;
          else             next_state = ST_FETCH;
`else
          next_state = last ? ST_DONE : ST_FETCH;
`endif
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) next_state = ST_IDLE;
  end

  // RAM data lands during WAIT; the checksum replaces the last sample in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      m_data_q <= '0;
    else if (state == ST_WAIT)
      m_data_q <= bus.mem_rd_data;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
    else if (sample_hs && last)
      m_data_q <= csum_q ^ m_data_q;
`endif
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign bus.m_valid   = (state == ST_SEND);
  assign bus.m_data    = m_data_q;
  assign bus.mem_rd_en = (state == ST_FETCH);
  assign bus.mem_addr  = addr;

endmodule

// File: tb/tb_sample_readout.sv
// Self-checking bench for sample_readout (ADDR_BITS=4): vector table, corner
// sequences and randomized readouts against a window-arithmetic model.
module tb_sample_readout;

  localparam int AB = 4;
  localparam int DB = 8;
  localparam int CB = 8;
  localparam int DEPTH = 1 << AB;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
  localparam int CSUM_W = 1;
`else
  localparam int CSUM_W = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AB-1:0] trig_addr;
  logic [CB-1:0] read_cnt, delay_cnt;
  logic          busy, done;

  sample_readout_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  sample_readout #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .trig_addr (trig_addr),
    .read_cnt  (read_cnt),
    .delay_cnt (delay_cnt),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Capture RAM with one cycle of read latency.
  logic [DB-1:0] mem [DEPTH];
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  // Stream sink: a transfer is logged when the next edge will complete it.
  logic [DB-1:0] got_q[$];
  int            done_cnt = 0;
  always @(negedge clk) begin
    if (!reset && !abort && bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
    if (!reset && done) done_cnt++;
  end

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected stream: read_cnt words starting pre samples before the trigger.
  task automatic build_expect(input logic [AB-1:0] t, input logic [CB-1:0] rc, input logic [CB-1:0] dc);
    int pre, base;
    logic [DB-1:0] x;
    exp_q.delete();
    pre  = (rc > dc) ? int'(rc) - int'(dc) : 0;
    base = ((int'(t) - pre) % DEPTH + DEPTH) % DEPTH;
    x    = '0;
    for (int k = 0; k < int'(rc); k++) begin
      exp_q.push_back(mem[(base + k) % DEPTH]);
      x ^= mem[(base + k) % DEPTH];
    end
    if (CSUM_W == 1 && rc != 0) exp_q.push_back(x);
  endtask

  task automatic pulse_start(input logic [AB-1:0] t, input logic [CB-1:0] rc, input logic [CB-1:0] dc);
    trig_addr = t;
    read_cnt  = rc;
    delay_cnt = dc;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall on sample value 3
  task automatic wait_done(input int mode, input int db, input string tag);
    int stall_n = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy && done_cnt > db) return;
      @(posedge clk); #1;
      if (mode == 1) begin
        bus.m_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (stall_n > 0 && stall_n < 5) begin
          check({tag, " stall valid"}, 32'(bus.m_valid), 1);
          check({tag, " stall data"}, 32'(bus.m_data), 3);
          bus.m_ready = 1'b0;
          stall_n++;
        end else if (stall_n == 0 && bus.m_valid && bus.m_data == 8'd3) begin
          bus.m_ready = 1'b0;
          stall_n = 1;
        end else begin
          bus.m_ready = 1'b1;
        end
      end
    end
    check({tag, " timeout"}, 0, 1);
  endtask

  task automatic compare(input string tag, input int qb, input int db);
    check({tag, " words"}, 32'(got_q.size() - qb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (qb + i < got_q.size())
        check($sformatf("%s word%0d", tag, i), 32'(got_q[qb + i]), 32'(exp_q[i]));
    check({tag, " done"}, 32'(done_cnt - db), 1);
  endtask

  task automatic run_readout(input logic [AB-1:0] t, input logic [CB-1:0] rc, input logic [CB-1:0] dc,
                             input int mode, input string tag, output int qb);
    int db;
    build_expect(t, rc, dc);
    qb = got_q.size();
    db = done_cnt;
    if (mode != 1) bus.m_ready = 1'b1;
    pulse_start(t, rc, dc);
    wait_done(mode, db, tag);
    compare(tag, qb, db);
  endtask

  typedef struct {
    logic [AB-1:0] trig;
    logic [CB-1:0] rc;
    logic [CB-1:0] dc;
    int            mode;
    int            exp_words;
    int            exp_first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int qb, db;
    logic [DB-1:0] ref_data;

    vecs[0] = '{trig: 4'd5,  rc: 8'd8,  dc: 8'd4, mode: 0, exp_words: 8,  exp_first: 1};
    vecs[1] = '{trig: 4'd2,  rc: 8'd6,  dc: 8'd2, mode: 0, exp_words: 6,  exp_first: 14};
    vecs[2] = '{trig: 4'd0,  rc: 8'd3,  dc: 8'd7, mode: 0, exp_words: 3,  exp_first: 0};
    vecs[3] = '{trig: 4'd15, rc: 8'd20, dc: 8'd0, mode: 1, exp_words: 20, exp_first: 11};
    vecs[4] = '{trig: 4'd9,  rc: 8'd1,  dc: 8'd1, mode: 1, exp_words: 1,  exp_first: 9};

    for (int i = 0; i < DEPTH; i++) mem[i] = DB'(i);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    trig_addr = '0; read_cnt = '0; delay_cnt = '0;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_addr",  32'(bus.mem_addr), 0);
    check("rst mem_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst m_data",    32'(bus.m_data), 0);
    check("rst m_valid",   32'(bus.m_valid), 0);
    check("rst busy",      32'(busy), 0);
    check("rst done",      32'(done), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table
    for (int v = 0; v < 5; v++) begin
      run_readout(vecs[v].trig, vecs[v].rc, vecs[v].dc, vecs[v].mode, $sformatf("vec%0d", v), qb);
      check($sformatf("vec%0d count", v), 32'(got_q.size() - qb), 32'(vecs[v].exp_words + CSUM_W));
      if (qb < got_q.size()) check($sformatf("vec%0d first", v), 32'(got_q[qb]), 32'(vecs[v].exp_first));
      @(posedge clk); #1;
    end

    // Latency to first valid; start and parameter changes mid-readout ignored
    build_expect(4'd5, 8'd8, 8'd4);
    qb = got_q.size(); db = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start(4'd5, 8'd8, 8'd4);
    check("lat e0 busy",  32'(busy), 1);
    check("lat e0 valid", 32'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("lat e1 rd_en", 32'(bus.mem_rd_en), 1);
    check("lat e1 addr",  32'(bus.mem_addr), 1);
    check("lat e1 valid", 32'(bus.m_valid), 0);
    trig_addr = 4'd9; read_cnt = 8'd3; delay_cnt = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat e2 rd_en", 32'(bus.mem_rd_en), 0);
    check("lat e2 valid", 32'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("lat e3 valid", 32'(bus.m_valid), 1);
    check("lat e3 data",  32'(bus.m_data), 1);
    wait_done(0, db, "lat");
    compare("lat", qb, db);

    // read_cnt = 0: done two edges after start is raised, no stream traffic
    qb = got_q.size(); db = done_cnt;
    pulse_start(4'd3, 8'd0, 8'd0);
    check("zero e0 done", 32'(done), 0);
    @(posedge clk); #1;
    check("zero e1 done", 32'(done), 1);
    @(posedge clk); #1;
    check("zero e2 done", 32'(done), 0);
    check("zero e2 busy", 32'(busy), 0);
    check("zero words",   32'(got_q.size() - qb), 0);
    check("zero pulses",  32'(done_cnt - db), 1);

    // Back-pressure on the third sample
    run_readout(4'd5, 8'd8, 8'd4, 2, "stall", qb);

    // Abort after two handshakes
    qb = got_q.size(); db = done_cnt;
    bus.m_ready = 1'b1;
    pulse_start(4'd5, 8'd8, 8'd4);
    for (int c = 0; c < 100 && (got_q.size() - qb) < 2; c++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy",  32'(busy), 0);
    check("abort valid", 32'(bus.m_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort words", 32'(got_q.size() - qb), 2);
    if (got_q.size() - qb >= 2) check("abort word1", 32'(got_q[qb + 1]), 2);
    check("abort no done", 32'(done_cnt - db), 0);

    // Abort wins over a handshake in the same cycle
    qb = got_q.size(); db = done_cnt;
    pulse_start(4'd5, 8'd8, 8'd4);
    for (int c = 0; c < 20 && !bus.m_valid; c++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_hs busy",  32'(busy), 0);
    check("abort_hs valid", 32'(bus.m_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_hs no done", 32'(done_cnt - db), 0);
    run_readout(4'd5, 8'd8, 8'd4, 0, "post_abort", qb);

    // Asynchronous reset mid-readout
    db = done_cnt;
    pulse_start(4'd2, 8'd6, 8'd2);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst busy",  32'(busy), 0);
    check("mid_rst valid", 32'(bus.m_valid), 0);
    check("mid_rst data",  32'(bus.m_data), 0);
    check("mid_rst addr",  32'(bus.mem_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst no done", 32'(done_cnt - db), 0);
    run_readout(4'd2, 8'd6, 8'd2, 0, "post_rst", qb);

    // Randomized readouts over random RAM contents
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DB'($urandom);
      run_readout(AB'($urandom), CB'($urandom_range(0, 40)), CB'($urandom_range(0, 45)), 1,
                  $sformatf("rnd%0d", r), qb);
      @(posedge clk); #1;
    end
    ref_data = '0;
    check("final idle", 32'(busy), 32'(ref_data));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
